io_event_serializer: RTL and testbench

Collects single-cycle event pulses from SoC sources and serializes them, one 8-bit event ID at a time, onto the uDMA event input of `pulp_io` (`event_valid_i` / `event_data_i` / `event_ready_o`). It sits directly upstream of the IO subsystem in the `sys_clk_i` domain. A per-line pending bit absorbs bursts, a round-robin arbiter picks among pending lines, and a small FIFO decouples the arbiter from downstream backpressure. Lost events are flagged.

---
 rtl/io_evt_pkg.sv | 20 ++
 rtl/io_evt_rr_arbiter.sv | 50 +++++
 rtl/io_event_serializer.sv | 148 ++++++++++++++
 tb/tb_io_event_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/io_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_evt_pkg
// Purpose  : Shared event-ID width, ID type and index-width helper for the
//            IO event serializer.
// Revision : 1.0  initial release
// ============================================================================
package io_evt_pkg;

    localparam int EVT_ID_W = 8;

    typedef logic [EVT_ID_W-1:0] evt_id_t;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_evt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : io_evt_rr_arbiter
// Purpose  : Round-robin pick of the first pending line at or above a pointer.
// Revision : 1.0  initial release
// ============================================================================
module io_evt_rr_arbiter
    import io_evt_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = idx_width(NUM_LINES)
) (
    input  logic [NUM_LINES-1:0] i_pend,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    input  logic                 i_en,
    output logic                 o_gnt_valid,
    output logic [IDX_W-1:0]     o_gnt_idx,
    output logic [NUM_LINES-1:0] o_gnt_clr
);

    localparam logic [IDX_W:0] c_num_lines = (IDX_W+1)'(NUM_LINES);

    logic [IDX_W:0]   w_cand;
    logic [IDX_W-1:0] w_sel;
    logic             w_found;

    // Scan offsets 0..N-1 from the pointer; the candidate wraps modulo N.
    always_comb begin
        w_cand  = '0;
        w_sel   = '0;
        w_found = 1'b0;
        o_gnt_idx = '0;
        o_gnt_clr = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            w_cand = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
            if (w_cand >= c_num_lines) begin
                w_cand = w_cand - c_num_lines;
            end
            w_sel = w_cand[IDX_W-1:0];
            if (i_en && !w_found && i_pend[w_sel]) begin
                w_found          = 1'b1;
                o_gnt_idx        = w_sel;
                o_gnt_clr[w_sel] = 1'b1;
            end
        end
        o_gnt_valid = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/io_event_serializer.sv
`default_nettype none
// ============================================================================
// Module   : io_event_serializer
// Purpose  : Serializes event pulses into 8-bit IDs for the uDMA event input.
//            Define IO_EVT_OVF_CNT_EN to add the saturating ovf_cnt_o counter.
// Revision : 1.0  initial release
// ============================================================================
module io_event_serializer
    import io_evt_pkg::*;
#(
    parameter int NUM_EVT_LINES = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_ni,
    input  logic [NUM_EVT_LINES-1:0] evt_i,
    output logic                     evt_valid_o,
    output evt_id_t                  evt_data_o,
    input  logic                     evt_ready_i,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i
`ifdef IO_EVT_OVF_CNT_EN
    ,
    output logic [7:0]               ovf_cnt_o
`endif
);

    localparam int IDX_W = idx_width(NUM_EVT_LINES);
    localparam int PTR_W = idx_width(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] c_last_line = IDX_W'(NUM_EVT_LINES - 1);
    localparam logic [PTR_W:0]   c_depth     = (PTR_W+1)'(FIFO_DEPTH);

    if (NUM_EVT_LINES < 2 || NUM_EVT_LINES > (1 << EVT_ID_W)) begin : g_chk_lines
        $error("NUM_EVT_LINES must be in 2..2**EVT_ID_W");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    logic [NUM_EVT_LINES-1:0] r_pend;
    logic [IDX_W-1:0]         r_rr_ptr;
    logic                     r_ovf;
    evt_id_t                  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W:0]           r_count;

    logic                     w_full;
    logic                     w_valid;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_gnt_valid;
    logic [IDX_W-1:0]         w_gnt_idx;
    logic [NUM_EVT_LINES-1:0] w_gnt_clr;
    logic                     w_ovf_evt;

    assign w_full  = (r_count == c_depth);
    assign w_valid = (r_count != '0);
    assign w_push  = w_gnt_valid;
    assign w_pop   = w_valid & evt_ready_i;

    // Arbiter is gated by the registered count, so a same-cycle pop never frees a slot.
    io_evt_rr_arbiter #(
        .NUM_LINES (NUM_EVT_LINES),
        .IDX_W     (IDX_W)
    ) u_arb (
        .i_pend      (r_pend),
        .i_rr_ptr    (r_rr_ptr),
        .i_en        (!w_full),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_clr   (w_gnt_clr)
    );

    // A granted line that pulses again keeps its pending bit as a fresh event.
    assign w_ovf_evt = |(evt_i & r_pend & ~w_gnt_clr);

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_pend   <= '0;
            r_rr_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_gnt_clr) | evt_i;
            if (w_gnt_valid) begin
                r_rr_ptr <= (w_gnt_idx == c_last_line) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge sys_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= EVT_ID_W'(w_gnt_idx);
        end
    end

    assign evt_valid_o = w_valid;
    assign evt_data_o  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign ovf_o       = r_ovf;

`ifdef IO_EVT_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            r_ovf_cnt <= '0;
        end else if (w_ovf_evt) begin
            if (ovf_clr_i) begin
                r_ovf_cnt <= 8'd1;
            end else if (r_ovf_cnt != 8'hFF) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end else if (ovf_clr_i) begin
            r_ovf_cnt <= '0;
        end
    end

    assign ovf_cnt_o = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_event_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_event_serializer
// Purpose  : Scoreboard bench for io_event_serializer with a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_event_serializer;

    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] evt;
    logic         evt_valid;
    logic [7:0]   evt_data;
    logic         evt_ready;
    logic         ovf;
    logic         ovf_clr;
`ifdef IO_EVT_OVF_CNT_EN
    logic [7:0]   ovf_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    io_event_serializer #(
        .NUM_EVT_LINES (N),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_ni  (rst_n),
        .evt_i       (evt),
        .evt_valid_o (evt_valid),
        .evt_data_o  (evt_data),
        .evt_ready_i (evt_ready),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr)
`ifdef IO_EVT_OVF_CNT_EN
        ,
        .ovf_cnt_o   (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending set, pointer, FIFO contents and expected ID stream.
    bit m_pend [N];
    int m_rr;
    int mq[$];
    int sb_q[$];
    bit m_ovf;
    int m_cnt;
    int m_g;
    bit m_lost;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_rr  = 0;
            mq.delete();
            sb_q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            m_g = -1;
            if (mq.size() < DEPTH) begin
                for (int k = 0; k < N; k++) begin
                    if (m_pend[(m_rr + k) % N]) begin
                        m_g = (m_rr + k) % N;
                        break;
                    end
                end
            end
            m_lost = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (evt[i] && m_pend[i] && i != m_g) m_lost = 1'b1;
            end
            if (m_g >= 0) m_pend[m_g] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (evt[i]) m_pend[i] = 1'b1;
            end
            if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
            if (m_g >= 0) begin
                mq.push_back(m_g);
                sb_q.push_back(m_g);
                m_rr = (m_g + 1) % N;
            end
            if (m_lost) begin
                m_ovf = 1'b1;
                m_cnt = ovf_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", 64'(evt_valid), 64'(mq.size() > 0));
            check("ovf", 64'(ovf), 64'(m_ovf));
`ifdef IO_EVT_OVF_CNT_EN
            check("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
`endif
            if (evt_valid && evt_ready) begin
                if (sb_q.size() == 0) check("unexpected_id", 64'(evt_data), 64'hFFFF);
                else                  check("data", 64'(evt_data), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic cyc(input logic [N-1:0] e, input logic r, input logic c);
        evt       = e;
        evt_ready = r;
        ovf_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while ((sb_q.size() != 0 || mq.size() != 0) && budget > 0) begin
            cyc('0, 1'b1, 1'b0);
            budget--;
        end
        check("drain_budget", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        evt       = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_data", 64'(evt_data), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
`ifdef IO_EVT_OVF_CNT_EN
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse on line 5 with ready high.
        cyc(N'(1) << 5, 1'b1, 1'b0);
        repeat (4) cyc('0, 1'b1, 1'b0);

        // Six lines at once with ready low, then release.
        cyc(N'(6'h3F), 1'b0, 1'b0);
        repeat (6) cyc('0, 1'b0, 1'b0);
        check("burst_no_ovf", 64'(ovf), 64'd0);
        drain();

        // Overflow on line 31 with the FIFO full, clears and clear-vs-set.
        cyc(N'(4'hF), 1'b0, 1'b0);
        repeat (5) cyc('0, 1'b0, 1'b0);
        repeat (3) cyc(N'(1) << 31, 1'b0, 1'b0);
        check("ovf_set", 64'(ovf), 64'd1);
        cyc('0, 1'b0, 1'b1);
        check("ovf_cleared", 64'(ovf), 64'd0);
        cyc(N'(1) << 31, 1'b0, 1'b1);
        check("ovf_set_wins", 64'(ovf), 64'd1);
        repeat (300) cyc(N'(1) << 31, 1'b0, 1'b0);
        cyc(N'(1) << 31, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        drain();

        // Lines 3 and 30 pulsing every cycle.
        repeat (12) cyc((N'(1) << 3) | (N'(1) << 30), 1'b1, 1'b0);
        drain();

        // Asynchronous reset with entries queued.
        cyc(N'(4'hE), 1'b0, 1'b0);
        repeat (4) cyc('0, 1'b0, 1'b0);
        check("pre_rst_valid", 64'(evt_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(evt_valid), 64'd0);
        check("async_rst_data", 64'(evt_data), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(N'(1) << 7, 1'b1, 1'b0);
        drain();

        // Randomized traffic.
        for (int t = 0; t < 3000; t++) begin
            cyc(N'($urandom & $urandom & $urandom & $urandom),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 31) == 0));
        end
        cyc('0, 1'b1, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
